// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states and parity mode encodings.
// Also used by the receiver side.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic PARITY_MODE_EVEN = 1'b0;
    localparam logic PARITY_MODE_ODD  = 1'b1;

    // Seed value for a running XOR parity accumulator in the given mode.
    function automatic logic parity_seed(input int odd);
        return (odd != 0) ? PARITY_MODE_ODD : PARITY_MODE_EVEN;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: runs 0..BAUD_DIV-1 while enabled, bit_end_o flags the last cycle.
// No latency beyond the counter register; clear_i restarts the period on the next edge.
module uart_baud_gen #(
    parameter int BAUD_DIV = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en_i,
    input  logic clear_i,
    output logic bit_end_o
);
    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        bit_end_o = en_i && (cnt_q == CW'(BAUD_DIV - 1));
        cnt_d     = cnt_q + CW'(1);
        if (clear_i || !en_i || bit_end_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: pops a byte from the TX FIFO and sends start/data(LSB first)/[parity]/stop.
// tx falls at the pop edge; FIFO is only read when idle or in the final stop cycle.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_SIZE  = 8,
    parameter int BAUD_DIV   = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [DATA_SIZE-1:0] fifo_data,
    input  logic                 fifo_empty,
    output logic                 fifo_read,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);
    localparam int IW = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;

    tx_state_e            state_q, state_d;
    logic [DATA_SIZE-1:0] shift_q, shift_d;
    logic [IW-1:0]        bit_idx_q, bit_idx_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 bit_end;
    logic                 last_stop;

    uart_baud_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud (
        .clk       (clk),
        .reset_n   (reset_n),
        .en_i      (state_q != IDLE),
        .clear_i   (fifo_read),
        .bit_end_o (bit_end)
    );

    // bit_idx_q doubles as the stop-bit counter while in STOP.
    assign last_stop = (state_q == STOP) && bit_end && (bit_idx_q == IW'(STOP_BITS - 1));
    assign fifo_read = reset_n && !fifo_empty && ((state_q == IDLE) || last_stop);

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        par_d     = par_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    par_d   = par_q ^ shift_q[0];
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == IW'(DATA_SIZE - 1)) begin
                        bit_idx_d = '0;
                        if (PARITY_EN != 0) begin
                            state_d = PARITY;
                            tx_d    = par_q ^ shift_q[0];
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + IW'(1);
                        tx_d      = shift_q[1];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d   = STOP;
                    bit_idx_d = '0;
                    tx_d      = 1'b1;
                end
            end
            STOP: begin
                if (last_stop) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    tx_d    = 1'b1;
                end else if (bit_end) begin
                    bit_idx_d = bit_idx_q + IW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        // A pop overrides the end-of-frame return to IDLE so frames run back to back.
        if (fifo_read) begin
            state_d   = START;
            shift_d   = fifo_data;
            bit_idx_d = '0;
            par_d     = parity_seed(PARITY_ODD);
            tx_d      = 1'b0;
            busy_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            par_q     <= par_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign tx      = tx_q;
    assign busy    = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Four transmitter configurations driven from queue-modelled FIFOs; each cycle the line
// level, busy, tx_done and fifo_read are compared against an expected per-cycle waveform.
module tb_uart_tx;
    localparam int BD = 4;
    localparam int ND = 4;

    // Per-instance configuration: plain, even parity, odd parity, two stop bits.
    localparam int PE[ND] = '{0, 1, 1, 0};
    localparam int PO[ND] = '{0, 0, 1, 0};
    localparam int SB[ND] = '{1, 1, 1, 2};

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] fdat [ND];
    logic       femp [ND];
    logic       frd  [ND];
    logic       txs  [ND];
    logic       bsy  [ND];
    logic       dn   [ND];

    logic [7:0] fq [ND][$];
    logic       eq [ND][$];
    logic       dpend    [ND];
    logic       pop_pend [ND];
    int         npush [ND];
    int         npop  [ND];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_tx #(.DATA_SIZE(8), .BAUD_DIV(BD), .PARITY_EN(PE[0]), .PARITY_ODD(PO[0]), .STOP_BITS(SB[0])) u_dut0 (
        .clk(clk), .reset_n(reset_n), .fifo_data(fdat[0]), .fifo_empty(femp[0]),
        .fifo_read(frd[0]), .tx(txs[0]), .busy(bsy[0]), .tx_done(dn[0]));
    uart_tx #(.DATA_SIZE(8), .BAUD_DIV(BD), .PARITY_EN(PE[1]), .PARITY_ODD(PO[1]), .STOP_BITS(SB[1])) u_dut1 (
        .clk(clk), .reset_n(reset_n), .fifo_data(fdat[1]), .fifo_empty(femp[1]),
        .fifo_read(frd[1]), .tx(txs[1]), .busy(bsy[1]), .tx_done(dn[1]));
    uart_tx #(.DATA_SIZE(8), .BAUD_DIV(BD), .PARITY_EN(PE[2]), .PARITY_ODD(PO[2]), .STOP_BITS(SB[2])) u_dut2 (
        .clk(clk), .reset_n(reset_n), .fifo_data(fdat[2]), .fifo_empty(femp[2]),
        .fifo_read(frd[2]), .tx(txs[2]), .busy(bsy[2]), .tx_done(dn[2]));
    uart_tx #(.DATA_SIZE(8), .BAUD_DIV(BD), .PARITY_EN(PE[3]), .PARITY_ODD(PO[3]), .STOP_BITS(SB[3])) u_dut3 (
        .clk(clk), .reset_n(reset_n), .fifo_data(fdat[3]), .fifo_empty(femp[3]),
        .fifo_read(frd[3]), .tx(txs[3]), .busy(bsy[3]), .tx_done(dn[3]));

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic refresh(input int d);
        femp[d] = (fq[d].size() == 0);
        fdat[d] = (fq[d].size() != 0) ? fq[d][0] : 8'h00;
    endtask

    task automatic push_byte(input int d, input logic [7:0] b);
        fq[d].push_back(b);
        npush[d]++;
        refresh(d);
    endtask

    task automatic clear_fifo(input int d);
        npush[d] -= fq[d].size();
        fq[d].delete();
        refresh(d);
    endtask

    // Expected line waveform of one frame, one entry per clock cycle.
    task automatic push_frame(input int d, input logic [7:0] b);
        logic lv [$];
        lv.push_back(1'b0);
        for (int i = 0; i < 8; i++) lv.push_back(b[i]);
        if (PE[d] != 0) lv.push_back(((^b) ^ (PO[d] != 0)) ? 1'b1 : 1'b0);
        for (int i = 0; i < SB[d]; i++) lv.push_back(1'b1);
        foreach (lv[k]) for (int r = 0; r < BD; r++) eq[d].push_back(lv[k]);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Reference model: compare on falling edges, apply FIFO pops just after rising edges.
    initial begin
        logic etx, ebsy, edn, erd;
        for (int d = 0; d < ND; d++) begin
            dpend[d] = 1'b0;
            pop_pend[d] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < ND; d++) begin
                if (!reset_n) begin
                    eq[d].delete();
                    dpend[d] = 1'b0;
                end
                etx  = (eq[d].size() != 0) ? eq[d][0] : 1'b1;
                ebsy = (eq[d].size() != 0);
                edn  = dpend[d];
                dpend[d] = (eq[d].size() == 1);
                if (eq[d].size() != 0) void'(eq[d].pop_front());
                erd = reset_n && !femp[d] && (eq[d].size() == 0);
                check($sformatf("tx%0d", d), int'(txs[d]), int'(etx));
                check($sformatf("busy%0d", d), int'(bsy[d]), int'(ebsy));
                check($sformatf("tx_done%0d", d), int'(dn[d]), int'(edn));
                check($sformatf("fifo_read%0d", d), int'(frd[d]), int'(erd));
                pop_pend[d] = frd[d];
            end
            @(posedge clk);
            #1;
            for (int d = 0; d < ND; d++) begin
                if (pop_pend[d] && fq[d].size() != 0) begin
                    push_frame(d, fq[d].pop_front());
                    npop[d]++;
                    refresh(d);
                end
            end
        end
    end

    initial begin
        int budget;
        reset_n = 1'b0;
        for (int d = 0; d < ND; d++) begin
            npush[d] = 0;
            npop[d]  = 0;
            refresh(d);
        end

        // Reset held with data pending: no pop, line idle.
        cycles(1);
        for (int d = 0; d < ND; d++) push_byte(d, 8'h55);
        cycles(3);
        for (int d = 0; d < ND; d++) begin
            check($sformatf("rst_read%0d", d), int'(frd[d]), 0);
            check($sformatf("rst_tx%0d", d), int'(txs[d]), 1);
            check($sformatf("rst_busy%0d", d), int'(bsy[d]), 0);
            clear_fifo(d);
        end
        cycles(1);
        reset_n = 1'b1;
        cycles(6);

        // Directed frames: 6C plain, AF even/odd parity, 00 with two stop bits.
        push_byte(0, 8'h6C);
        push_byte(1, 8'hAF);
        push_byte(2, 8'hAF);
        push_byte(3, 8'h00);
        cycles(60);

        // Back-to-back frames.
        push_byte(0, 8'hAF);
        push_byte(0, 8'h64);
        for (int d = 1; d < ND; d++) begin
            push_byte(d, 8'hFF);
            push_byte(d, 8'h01);
        end
        cycles(110);

        // Random traffic with random arrival gaps.
        for (int i = 0; i < 60; i++) begin
            push_byte($urandom_range(0, ND - 1), 8'($urandom));
            cycles($urandom_range(0, 40));
        end
        budget = 4000;
        while (budget > 0 && (fq[0].size() + fq[1].size() + fq[2].size() + fq[3].size()
                              + eq[0].size() + eq[1].size() + eq[2].size() + eq[3].size()) != 0) begin
            cycles(1);
            budget--;
        end
        check("drain_budget", int'(budget > 0), 1);
        cycles(4);

        // Reset in the middle of the data bits, then a clean frame after release.
        for (int d = 0; d < ND; d++) push_byte(d, 8'hAF);
        cycles(20);
        reset_n = 1'b0;
        #1;
        for (int d = 0; d < ND; d++) begin
            check($sformatf("abort_tx%0d", d), int'(txs[d]), 1);
            check($sformatf("abort_busy%0d", d), int'(bsy[d]), 0);
            check($sformatf("abort_read%0d", d), int'(frd[d]), 0);
            push_byte(d, 8'h64);
        end
        cycles(3);
        reset_n = 1'b1;
        cycles(70);

        for (int d = 0; d < ND; d++) begin
            check($sformatf("pops%0d", d), npop[d], npush[d]);
            check($sformatf("fifo_left%0d", d), fq[d].size(), 0);
            check($sformatf("frame_left%0d", d), eq[d].size(), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
